nor_sweep_checker: RTL and testbench
====================================

NOR_SWEEP_CHECKER -- requirements
Module: nor_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of NOR inputs driven; legal range 2..16.
REQ-002 SHALL have parameter HOLD, default 2: clock cycles each pattern is held; legal range 1..255.
REQ-003 SHALL have parameter ERR_W, default 8: width of the mismatch counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: begins a sweep when sampled high in IDLE or DONE.
REQ-007 SHALL have port pattern, output, WIDTH: stimulus vector driven to the NOR device under test.
REQ-008 SHALL have port dut_resp, input, 1: response of the device under test to pattern.
REQ-009 SHALL have port busy, output, 1: high while a sweep is running (APPLY state).
REQ-010 SHALL have port done, output, 1: high in DONE state.
REQ-011 SHALL have port pass, output, 1: high in DONE when err_count equals 0.
REQ-012 SHALL have port err_count, output, ERR_W: number of mismatching patterns, saturating.
REQ-013 SHALL have port fail_pattern, output, WIDTH: first pattern that mismatched in the current sweep.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, DONE; transitions IDLE->APPLY and DONE->APPLY on start=1, APPLY->DONE after the last pattern is sampled, and no other transitions.
REQ-015 SHALL, on entry to APPLY, set pattern=0, clear err_count and fail_pattern to 0, and reset the hold counter, all on the same edge that samples start.
REQ-016 SHALL hold each pattern value for exactly HOLD cycles, then advance pattern by 1.
REQ-017 SHALL sample dut_resp on the last of the HOLD cycles of each pattern and compare it with the expected value, the NOR-reduction of pattern (1 only when pattern is all zeros).
REQ-018 SHALL, on a mismatch, increment err_count, holding it at 2^ERR_W-1 instead of wrapping.
REQ-019 SHALL, on the first mismatch of a sweep, load fail_pattern with the current pattern and leave it unchanged for the rest of the sweep.
REQ-020 SHALL, when the all-ones pattern has been sampled, move to DONE on the next edge without wrapping pattern; pattern holds all-ones in DONE.
REQ-021 SHALL give a sweep length of exactly 2^WIDTH*HOLD cycles from the start edge to the edge that asserts done.
REQ-022 SHALL ignore start while in APPLY, with no restart and no effect on any counter.
REQ-023 SHALL keep busy=1 only in APPLY and done=1 only in DONE; pass SHALL be 0 outside DONE.
REQ-024 SHALL keep done, pass, err_count and fail_pattern stable in DONE until start or rst.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE with pattern=0, busy=0, done=0, pass=0, err_count=0, fail_pattern=0, and hold counter=0.
REQ-026 SHALL give rst priority over start and over every in-progress sweep; a reset mid-sweep abandons the sweep with no partial result retained.

Verification (WIDTH=4, HOLD=2, ERR_W=8 unless noted)
REQ-027 SHALL cover this scenario: dut_resp driven by an ideal NOR of pattern, start pulsed 1 cycle -> busy for 32 cycles, pattern steps 0..15 every 2 cycles, then done=1, pass=1, err_count=0.
REQ-028 SHALL cover this scenario: dut_resp stuck at 0 -> done after 32 cycles, err_count=1, fail_pattern=4'h0, pass=0.
REQ-029 SHALL cover this scenario: dut_resp stuck at 1 -> err_count=15, fail_pattern=4'h1, pass=0.
REQ-030 SHALL cover this scenario: ERR_W=3, dut_resp stuck at 1 -> err_count saturates at 7, fail_pattern=4'h1.
REQ-031 SHALL cover this scenario: start re-pulsed at cycle 10 of a sweep -> ignored and done still at cycle 32; then rst at cycle 5 of a new sweep -> IDLE with all outputs 0 on the next edge.
REQ-032 SHALL cover this scenario: start in DONE after a failing sweep, with an ideal response -> err_count and fail_pattern clear on the start edge, and the sweep ends with pass=1.

Source files
------------

// File: rtl/nor_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nor_sweep_checker
//  Description : Exhaustive stimulus sweep for a WIDTH-input NOR gate. Drives
//                every pattern 0..2^WIDTH-1 for HOLD cycles each, compares the
//                response on the last hold cycle against the NOR reduction of
//                the pattern, and reports a saturating mismatch count plus the
//                first failing pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module nor_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] pattern,
    input  logic             dut_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_pattern
);

    localparam logic [1:0]       c_S_IDLE    = 2'd0;
    localparam logic [1:0]       c_S_APPLY   = 2'd1;
    localparam logic [1:0]       c_S_DONE    = 2'd2;
    localparam logic [7:0]       c_HOLD_LAST = 8'(HOLD - 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX   = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_pattern;
    logic [7:0]       r_hold;
    logic [ERR_W-1:0] r_err_count;
    logic [WIDTH-1:0] r_fail_pattern;

    logic w_launch;
    logic w_sample;
    logic w_last;
    logic w_expected;
    logic w_mismatch;

    // A sweep launches only from IDLE or DONE; start during APPLY is ignored.
    assign w_launch   = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    // The response is judged on the final hold cycle of each pattern.
    assign w_sample   = (r_state == c_S_APPLY) && (r_hold == c_HOLD_LAST);
    assign w_last     = w_sample && (&r_pattern);
    assign w_expected = ~(|r_pattern);
    assign w_mismatch = w_sample && (dut_resp != w_expected);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: the edge that samples the all-ones pattern ends the sweep.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_next = c_S_APPLY;
            c_S_APPLY: if (w_last) w_state_next = c_S_DONE;
            c_S_DONE:  if (start) w_state_next = c_S_APPLY;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    // Status outputs decoded from the state and the final mismatch count.
    always_comb begin
        busy = (r_state == c_S_APPLY);
        done = (r_state == c_S_DONE);
        pass = (r_state == c_S_DONE) && (r_err_count == '0);
    end

    // Sweep datapath: pattern/hold stepping, mismatch counting, first-fail capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern      <= '0;
            r_hold         <= '0;
            r_err_count    <= '0;
            r_fail_pattern <= '0;
        end else if (w_launch) begin
            r_pattern      <= '0;
            r_hold         <= '0;
            r_err_count    <= '0;
            r_fail_pattern <= '0;
        end else if (r_state == c_S_APPLY) begin
            if (w_mismatch) begin
                if (r_err_count != c_ERR_MAX) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
                // A zero count means no earlier mismatch in this sweep; the
                // count never returns to zero because it saturates.
                if (r_err_count == '0) begin
                    r_fail_pattern <= r_pattern;
                end
            end
            if (w_sample) begin
                r_hold <= '0;
                if (!w_last) begin
                    r_pattern <= r_pattern + WIDTH'(1);
                end
            end else begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign pattern      = r_pattern;
    assign err_count    = r_err_count;
    assign fail_pattern = r_fail_pattern;

endmodule
`default_nettype wire

// File: tb/tb_nor_sweep_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_nor_sweep_checker
//  Description : Directed bench for nor_sweep_checker (WIDTH=4, HOLD=2) with a
//                second instance at ERR_W=3 fed a stuck-at-1 response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nor_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dut_resp;
    logic [3:0] pattern;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] fail_pattern;

    logic [3:0] pattern_s;
    logic       busy_s, done_s, pass_s;
    logic [2:0] err_count_s;
    logic [3:0] fail_pattern_s;
    logic       resp_s = 1'b1;

    int mode = 0;  // 0: ideal NOR, 1: stuck at 0, 2: stuck at 1
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nor_sweep_checker #(.WIDTH(4), .HOLD(2), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .dut_resp(dut_resp), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_pattern(fail_pattern)
    );

    nor_sweep_checker #(.WIDTH(4), .HOLD(2), .ERR_W(3)) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern_s),
        .dut_resp(resp_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_count_s), .fail_pattern(fail_pattern_s)
    );

    // Response model for the main instance.
    always_comb begin
        dut_resp = 1'b1;
        case (mode)
            0:       dut_resp = (pattern == 4'd0);
            1:       dut_resp = 1'b0;
            default: dut_resp = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch a sweep (called #1 after an edge) and follow it until done,
    // an optional mid-sweep reset, or a cycle budget. cycles counts edges after
    // the start edge; seq_ok tracks busy and the pattern staircase k/2.
    task automatic do_sweep(input int repulse_at, input int rst_at,
                            output int cycles, output bit seq_ok,
                            output logic [31:0] err0, output logic [31:0] fail0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        seq_ok = 1'b1;
        err0 = 32'(err_count);
        fail0 = 32'(fail_pattern);
        while (!done && cycles < 100) begin
            if (int'(pattern) != cycles / 2 || !busy) seq_ok = 1'b0;
            if (cycles == rst_at) rst = 1'b1;
            if (cycles == repulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    int          cyc;
    bit          ok;
    logic [31:0] e0, f0;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_pattern", 32'(pattern), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fail", 32'(fail_pattern), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 0);

        // Ideal NOR
        mode = 0;
        do_sweep(-1, -1, cyc, ok, e0, f0);
        check("ideal_cycles", cyc, 32);
        check("ideal_staircase", 32'(ok), 1);
        check("ideal_done", 32'(done), 1);
        check("ideal_busy", 32'(busy), 0);
        check("ideal_pass", 32'(pass), 1);
        check("ideal_err", 32'(err_count), 0);
        check("ideal_pattern", 32'(pattern), 15);
        // Saturating instance ran alongside with a stuck-at-1 response
        check("sat_done", 32'(done_s), 1);
        check("sat_err", 32'(err_count_s), 7);
        check("sat_fail", 32'(fail_pattern_s), 1);
        check("sat_pass", 32'(pass_s), 0);
        // DONE is stable without start
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", 32'(done), 1);
        check("hold_pass", 32'(pass), 1);
        check("hold_pattern", 32'(pattern), 15);

        // Stuck at 0: only pattern 0 mismatches
        mode = 1;
        do_sweep(-1, -1, cyc, ok, e0, f0);
        check("s0_cycles", cyc, 32);
        check("s0_err", 32'(err_count), 1);
        check("s0_fail", 32'(fail_pattern), 0);
        check("s0_pass", 32'(pass), 0);

        // Stuck at 1: patterns 1..15 mismatch
        mode = 2;
        do_sweep(-1, -1, cyc, ok, e0, f0);
        check("s1_cycles", cyc, 32);
        check("s1_err", 32'(err_count), 15);
        check("s1_fail", 32'(fail_pattern), 1);
        check("s1_pass", 32'(pass), 0);
        check("s1_done", 32'(done), 1);

        // Restart from a failing DONE with an ideal response
        mode = 0;
        do_sweep(-1, -1, cyc, ok, e0, f0);
        check("restart_err_clear", e0, 0);
        check("restart_fail_clear", f0, 0);
        check("restart_pass", 32'(pass), 1);
        check("restart_cycles", cyc, 32);

        // Start re-pulsed at cycle 10 is ignored
        do_sweep(10, -1, cyc, ok, e0, f0);
        check("repulse_cycles", cyc, 32);
        check("repulse_staircase", 32'(ok), 1);
        check("repulse_pass", 32'(pass), 1);

        // Reset at cycle 5 of a failing sweep abandons it
        mode = 2;
        do_sweep(-1, 5, cyc, ok, e0, f0);
        check("midrst_cycles", cyc, 6);
        check("midrst_pattern", 32'(pattern), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_pass", 32'(pass), 0);
        check("midrst_err", 32'(err_count), 0);
        check("midrst_fail", 32'(fail_pattern), 0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle_busy", 32'(busy), 0);
        check("midrst_idle_pattern", 32'(pattern), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
